// File: rtl/adder_share_pkg.sv
// Shared defaults and width helpers for the adder time-sharing scheduler.
// Tag layout in the top is {vld, id}, with id sized by bits_for(NREQ).
package adder_share_pkg;
    localparam int NREQ_DEF     = 4;
    localparam int WIDTH_DEF    = 8;
    localparam int ADD_LAT_DEF  = 2;
    localparam int OUTS_MAX_DEF = 2;

    // Bits needed to encode values 0..n-1, never less than one.
    function automatic int bits_for(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int ID_W  = bits_for(NREQ_DEF);
    localparam int CNT_W = bits_for(OUTS_MAX_DEF + 1);
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or after ptr_i,
// wrapping modulo NREQ; one-hot grant plus its encoded index.
module rr_arbiter
    import adder_share_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    localparam int IDW = bits_for(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  ptr_i,
    output logic [NREQ-1:0] grant_o,
    output logic [IDW-1:0]  idx_o,
    output logic            any_o
);
    always_comb begin
        int         j;
        logic       found;
        logic [IDW-1:0] jj;
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        found   = 1'b0;
        j       = 0;
        jj      = '0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(ptr_i) + k;
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            jj = IDW'(j);
            if (!found && req_i[jj]) begin
                grant_o[jj] = 1'b1;
                idx_o       = jj;
                found       = 1'b1;
            end
        end
        any_o = found;
    end
endmodule

// File: rtl/adder_share_sched.sv
// Round-robin scheduler sharing one pipelined adder among NREQ requesters;
// a {vld,id} tag pipe follows each op through the adder to route the result back.
module adder_share_sched
    import adder_share_pkg::*;
#(
    parameter int NREQ     = NREQ_DEF,
    parameter int WIDTH    = WIDTH_DEF,
    parameter int ADD_LAT  = ADD_LAT_DEF,
    parameter int OUTS_MAX = OUTS_MAX_DEF
) (
    input  logic                  enable,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    input  logic [NREQ-1:0]       req_cin,
    output logic [WIDTH-1:0]      add_a,
    output logic [WIDTH-1:0]      add_b,
    output logic                  add_cin,
    input  logic [WIDTH-1:0]      add_sum,
    input  logic                  add_cout,
    output logic [NREQ-1:0]       rsp_valid,
    output logic [WIDTH-1:0]      rsp_sum,
    output logic                  rsp_cout,
    output logic                  busy
);
    localparam int TID_W = bits_for(NREQ);
    localparam int TCNT_W = bits_for(OUTS_MAX + 1);

    typedef struct packed {
        logic             vld;
        logic [TID_W-1:0] id;
    } tag_t;

    logic [NREQ-1:0]  eligible;
    logic [NREQ-1:0]  grant;
    logic [TID_W-1:0] gnt_idx;
    logic             gnt_any;
    logic [TID_W-1:0] ptr_q, ptr_d;
    tag_t             tag_q [ADD_LAT+1];
    tag_t             ret_tag;
    logic [NREQ-1:0]  ret_onehot;
    logic [NREQ-1:0]  busy_vec;
    logic [WIDTH-1:0] add_a_q, add_a_d, add_b_q, add_b_d, rsp_sum_q;
    logic             add_cin_q, add_cin_d, rsp_cout_q;
    logic [NREQ-1:0]  rsp_valid_q;

    assign ret_tag = tag_q[ADD_LAT];

    // Per-requester eligibility and outstanding counter; a grant and a return
    // for the same requester in one cycle cancel out.
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
        logic [TCNT_W-1:0] cnt_q, cnt_d;

        assign eligible[gi]   = req_valid[gi] && (cnt_q < TCNT_W'(OUTS_MAX));
        assign ret_onehot[gi] = ret_tag.vld && (ret_tag.id == TID_W'(gi));
        assign busy_vec[gi]   = (cnt_q != '0);

        always_comb begin
            cnt_d = cnt_q;
            if (grant[gi] && !ret_onehot[gi]) begin
                cnt_d = cnt_q + TCNT_W'(1);
            end else if (!grant[gi] && ret_onehot[gi]) begin
                cnt_d = cnt_q - TCNT_W'(1);
            end
        end

        always_ff @(posedge enable or negedge rst) begin
            if (!rst) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end
    end

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req_i   (eligible),
        .ptr_i   (ptr_q),
        .grant_o (grant),
        .idx_o   (gnt_idx),
        .any_o   (gnt_any)
    );

    always_comb begin
        ptr_d     = ptr_q;
        add_a_d   = '0;
        add_b_d   = '0;
        add_cin_d = 1'b0;
        if (gnt_any) begin
            ptr_d = (gnt_idx == TID_W'(NREQ - 1)) ? '0 : gnt_idx + TID_W'(1);
        end
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                add_a_d   = req_a[i*WIDTH +: WIDTH];
                add_b_d   = req_b[i*WIDTH +: WIDTH];
                add_cin_d = req_cin[i];
            end
        end
    end

    always_ff @(posedge enable or negedge rst) begin
        if (!rst) begin
            ptr_q       <= '0;
            add_a_q     <= '0;
            add_b_q     <= '0;
            add_cin_q   <= 1'b0;
            rsp_valid_q <= '0;
            rsp_sum_q   <= '0;
            rsp_cout_q  <= 1'b0;
            for (int k = 0; k <= ADD_LAT; k++) begin
                tag_q[k] <= '0;
            end
        end else begin
            ptr_q     <= ptr_d;
            add_a_q   <= add_a_d;
            add_b_q   <= add_b_d;
            add_cin_q <= add_cin_d;
            tag_q[0]  <= '{vld: gnt_any, id: gnt_idx};
            for (int k = 1; k <= ADD_LAT; k++) begin
                tag_q[k] <= tag_q[k-1];
            end
            // The last tag stage lines up with the adder output for that op.
            rsp_valid_q <= ret_onehot;
            rsp_sum_q   <= ret_tag.vld ? add_sum : '0;
            rsp_cout_q  <= ret_tag.vld ? add_cout : 1'b0;
        end
    end

    assign req_ready = grant;
    assign add_a     = add_a_q;
    assign add_b     = add_b_q;
    assign add_cin   = add_cin_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_cout  = rsp_cout_q;
    assign busy      = |busy_vec;
endmodule

// File: tb/tb_adder_share_sched.sv
// Bench for adder_share_sched: behavioural pipelined adder plus a queue-based
// model of grants, in-flight ops and returned results.
module tb_adder_share_sched;
    localparam int NREQ     = 4;
    localparam int WIDTH    = 8;
    localparam int ADD_LAT  = 2;
    localparam int OUTS_MAX = 2;

    logic                  enable = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req_valid, req_ready, req_cin, rsp_valid;
    logic [NREQ*WIDTH-1:0] req_a, req_b;
    logic [WIDTH-1:0]      add_a, add_b, add_sum, rsp_sum;
    logic                  add_cin, add_cout, rsp_cout, busy;

    adder_share_sched #(
        .NREQ(NREQ), .WIDTH(WIDTH), .ADD_LAT(ADD_LAT), .OUTS_MAX(OUTS_MAX)
    ) dut (
        .enable    (enable),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_cin   (add_cin),
        .add_sum   (add_sum),
        .add_cout  (add_cout),
        .rsp_valid (rsp_valid),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .busy      (busy)
    );

    always #5 enable = ~enable;

    // Shared adder: ADD_LAT register stages after the operand registers.
    logic [WIDTH:0] pipe [ADD_LAT];
    initial for (int k = 0; k < ADD_LAT; k++) pipe[k] = '0;
    always @(posedge enable) begin
        pipe[0] <= {1'b0, add_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};
        for (int k = 1; k < ADD_LAT; k++) pipe[k] <= pipe[k-1];
    end
    assign {add_cout, add_sum} = pipe[ADD_LAT-1];

    typedef struct {
        int             id;
        int             due;
        logic [WIDTH:0] res;
    } op_t;

    op_t              pend[$];
    int               edge_n;
    int               ptr_m;
    int               errors;
    int               checks;
    logic [WIDTH-1:0] exp_add_a;
    logic [WIDTH-1:0] va [NREQ];
    logic [WIDTH-1:0] vb [NREQ];
    logic             vc [NREQ];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    function automatic int outs(input int id);
        int n = 0;
        foreach (pend[k]) if (pend[k].id == id) n++;
        return n;
    endfunction

    task automatic rand_ops();
        for (int i = 0; i < NREQ; i++) begin
            va[i] = WIDTH'($urandom);
            vb[i] = WIDTH'($urandom);
            vc[i] = 1'($urandom);
        end
    endtask

    // Called just after a falling edge: check results of the last rising edge,
    // then present requests and check the grant for the next rising edge.
    task automatic step(input logic [NREQ-1:0] v, input string tag);
        logic [NREQ-1:0] exp_rsp;
        logic [NREQ-1:0] exp_rdy;
        logic [WIDTH:0]  exp_res;
        int              g;
        int              j;
        exp_rsp = '0;
        exp_res = '0;
        for (int k = pend.size() - 1; k >= 0; k--) begin
            if (pend[k].due == edge_n) begin
                exp_rsp[pend[k].id] = 1'b1;
                exp_res = pend[k].res;
                pend.delete(k);
            end
        end
        chk({tag, ":rsp_valid"}, 32'(rsp_valid), 32'(exp_rsp));
        if (exp_rsp != '0) begin
            chk({tag, ":rsp_sum"}, 32'(rsp_sum), 32'(exp_res[WIDTH-1:0]));
            chk({tag, ":rsp_cout"}, 32'(rsp_cout), 32'(exp_res[WIDTH]));
        end
        chk({tag, ":busy"}, 32'(busy), 32'(pend.size() != 0));
        chk({tag, ":add_a"}, 32'(add_a), 32'(exp_add_a));

        req_valid = v;
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*WIDTH +: WIDTH] = va[i];
            req_b[i*WIDTH +: WIDTH] = vb[i];
            req_cin[i]              = vc[i];
        end
        #1;
        g = -1;
        for (int k = 0; k < NREQ; k++) begin
            j = (ptr_m + k) % NREQ;
            if (g < 0 && v[j] && outs(j) < OUTS_MAX) g = j;
        end
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        chk({tag, ":req_ready"}, 32'(req_ready), 32'(exp_rdy));
        if (g >= 0) begin
            pend.push_back('{id: g, due: edge_n + ADD_LAT + 2,
                             res: {1'b0, va[g]} + {1'b0, vb[g]} + {{WIDTH{1'b0}}, vc[g]}});
            ptr_m     = (g + 1) % NREQ;
            exp_add_a = va[g];
        end else begin
            exp_add_a = '0;
        end
        @(posedge enable);
        edge_n++;
        @(negedge enable);
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        edge_n    = 0;
        ptr_m     = 0;
        exp_add_a = '0;
        rst       = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_cin   = '0;
        for (int i = 0; i < NREQ; i++) begin
            va[i] = '0; vb[i] = '0; vc[i] = 1'b0;
        end

        // Reset state
        repeat (2) @(posedge enable);
        @(negedge enable);
        chk("reset:add_a", 32'(add_a), 32'h0);
        chk("reset:add_b", 32'(add_b), 32'h0);
        chk("reset:add_cin", 32'(add_cin), 32'h0);
        chk("reset:rsp_valid", 32'(rsp_valid), 32'h0);
        chk("reset:rsp_sum", 32'(rsp_sum), 32'h0);
        chk("reset:busy", 32'(busy), 32'h0);
        req_valid = '1;
        #1;
        chk("reset:req_ready", 32'(req_ready), 32'h1);
        req_valid = '0;
        rst = 1'b1;
        @(negedge enable);

        // Single op
        va[0] = 8'h12; vb[0] = 8'h34; vc[0] = 1'b0;
        step(4'b0001, "single");
        repeat (5) step(4'b0000, "single_drain");

        // Overflow wrap with carry-in
        va[2] = 8'hFF; vb[2] = 8'h01; vc[2] = 1'b1;
        step(4'b0100, "overflow");
        repeat (5) step(4'b0000, "overflow_drain");

        // Fairness with all requesters valid
        for (int n = 0; n < 12; n++) begin
            rand_ops();
            step(4'b1111, "fair");
        end
        repeat (5) step(4'b0000, "fair_drain");

        // Outstanding cap and same-cycle grant/return for one requester
        for (int n = 0; n < 14; n++) begin
            rand_ops();
            step(4'b0010, "cap");
        end
        repeat (5) step(4'b0000, "cap_drain");

        // Reset with ops in flight
        for (int n = 0; n < 3; n++) begin
            rand_ops();
            step(4'b1011, "pre_rst");
        end
        repeat (2) step(4'b0000, "pre_rst_idle");
        rst = 1'b0;
        #1;
        chk("midrst:busy", 32'(busy), 32'h0);
        chk("midrst:rsp_valid", 32'(rsp_valid), 32'h0);
        @(posedge enable);
        @(negedge enable);
        rst = 1'b1;
        pend.delete();
        ptr_m     = 0;
        exp_add_a = '0;
        rand_ops();
        step(4'b1110, "post_rst");
        repeat (5) step(4'b0000, "post_rst_drain");

        // Random traffic
        for (int n = 0; n < 200; n++) begin
            rand_ops();
            step(NREQ'($urandom), "rand");
        end
        repeat (6) step(4'b0000, "final_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
